// File: rtl/ui_draw_sequencer_pkg.sv
// Shared types and defaults for the UI arrow-draw sequencer.
// State encoding, box geometry defaults, bus widths, one-hot helper.
package ui_draw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        CLEAR,
        LAUNCH,
        DRAW,
        RELEASE
    } state_e;

    localparam int N_ENG = 4;
    localparam int COL_W = 3;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int CLR_W = 8;
    localparam int TMO_W = 26;

    localparam logic [X_W-1:0] BOX_X0_DEF  = 8'd72;
    localparam logic [Y_W-1:0] BOX_Y0_DEF  = 7'd56;
    localparam int             BOX_W_DEF   = 16;
    localparam int             BOX_H_DEF   = 16;
    localparam int             TIMEOUT_DEF = 60_000_000;

    function automatic logic [1:0] oh2idx(input logic [N_ENG-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < N_ENG; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ui_draw_sequencer_if.sv
// Engine/VGA bus between the draw sequencer and its surroundings.
// master: sequencer side; slave: game control, engines and vga_adapter.
interface ui_draw_sequencer_if;
    import ui_draw_pkg::*;

    logic [N_ENG-1:0]       req;
    logic [N_ENG*COL_W-1:0] req_colour;
    logic [N_ENG-1:0]       eng_done;
    logic [N_ENG*X_W-1:0]   eng_x;
    logic [N_ENG*Y_W-1:0]   eng_y;
    logic [N_ENG-1:0]       eng_plot;
    logic [N_ENG-1:0]       eng_reset_n;
    logic [N_ENG-1:0]       eng_start;
    logic [X_W-1:0]         vga_x;
    logic [Y_W-1:0]         vga_y;
    logic [COL_W-1:0]       vga_colour;
    logic                   vga_plot;
    logic [N_ENG-1:0]       grant;
    logic                   busy;
    logic [N_ENG-1:0]       ack;
    logic                   timeout_err;

    modport master (
        input  req, req_colour, eng_done, eng_x, eng_y, eng_plot,
        output eng_reset_n, eng_start, vga_x, vga_y, vga_colour,
        output vga_plot, grant, busy, ack, timeout_err
    );

    modport slave (
        output req, req_colour, eng_done, eng_x, eng_y, eng_plot,
        input  eng_reset_n, eng_start, vga_x, vga_y, vga_colour,
        input  vga_plot, grant, busy, ack, timeout_err
    );

endinterface

// File: rtl/ui_draw_sequencer_arb.sv
// Combinational 4-way round-robin pick: first pending at/after rr_ptr.
// pending_i, rr_ptr_i in; one-hot grant_o and valid_o out.
module rr_arbiter4 (
    input  logic [3:0] pending_i,
    input  logic [1:0] rr_ptr_i,
    output logic [3:0] grant_o,
    output logic       valid_o
);

    always_comb begin
        logic [1:0] idx;
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr_i + 2'(k);
            if (!valid_o && pending_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ui_draw_sequencer.sv
// Shares one vga_adapter port among 4 arrow engines: latch, arbitrate,
// erase box, launch winner, mux its pixels. Ports: clk, reset_n, bus.
module ui_draw_sequencer
    import ui_draw_pkg::*;
#(
    parameter logic [X_W-1:0] BOX_X0      = BOX_X0_DEF,
    parameter logic [Y_W-1:0] BOX_Y0      = BOX_Y0_DEF,
    parameter int             BOX_W       = BOX_W_DEF,
    parameter int             BOX_H       = BOX_H_DEF,
    parameter int             TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    ui_draw_sequencer_if.master bus
);

    localparam int               CB       = $clog2(BOX_W);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(BOX_W * BOX_H - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e           state_q;
    logic [N_ENG-1:0] pending_q, pending_d;
    logic [N_ENG-1:0] grant_q;
    logic [1:0]       rr_q, gidx_q;
    logic [COL_W-1:0] colour_q;
    logic [CLR_W-1:0] clr_q;
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
    logic             repend_q;

    logic [N_ENG-1:0] arb_grant;
    logic             arb_valid;
    logic [1:0]       arb_idx;
    logic [3:0]       col_off;
    logic [4:0]       x_off, y_off;
    logic             in_service;

    rr_arbiter4 u_arb (
        .pending_i (pending_q),
        .rr_ptr_i  (rr_q),
        .grant_o   (arb_grant),
        .valid_o   (arb_valid)
    );

    assign arb_idx    = oh2idx(arb_grant);
    assign col_off    = 4'(arb_idx) * 4'd3;
    assign x_off      = {gidx_q, 3'b000};
    assign y_off      = 5'(gidx_q) * 5'd7;
    assign in_service = (state_q == CLEAR) || (state_q == LAUNCH)
                     || (state_q == DRAW)  || (state_q == RELEASE);

    // The owner's bit stays set through service, so a request seen
    // meanwhile is remembered in repend_q to survive the release clear.
    always_comb begin
        pending_d = pending_q | bus.req;
        if (state_q == RELEASE && !repend_q && !(|(bus.req & grant_q)))
            pending_d = pending_d & ~grant_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            rr_q      <= '0;
            gidx_q    <= '0;
            colour_q  <= '0;
            clr_q     <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            repend_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (in_service && |(bus.req & grant_q))
                repend_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (pending_q != '0) state_q <= ARB;
                end
                ARB: begin
                    if (arb_valid) begin
                        grant_q  <= arb_grant;
                        gidx_q   <= arb_idx;
                        colour_q <= bus.req_colour[col_off +: COL_W];
                        clr_q    <= '0;
                        repend_q <= 1'b0;
                        state_q  <= CLEAR;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                CLEAR: begin
                    if (clr_q == CLR_LAST) state_q <= LAUNCH;
                    else                   clr_q   <= clr_q + 1'b1;
                end
                LAUNCH: begin
                    tmo_q   <= '0;
                    state_q <= DRAW;
                end
                DRAW: begin
                    if (bus.eng_done[gidx_q]) begin
                        err_q   <= 1'b0;
                        state_q <= RELEASE;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= RELEASE;
                    end else begin
                        tmo_q   <= tmo_q + 1'b1;
                    end
                end
                RELEASE: begin
                    rr_q    <= gidx_q + 2'd1;
                    state_q <= (pending_d != '0) ? ARB : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.vga_x       = '0;
        bus.vga_y       = '0;
        bus.vga_colour  = '0;
        bus.vga_plot    = 1'b0;
        bus.eng_start   = '0;
        bus.eng_reset_n = '0;
        bus.ack         = '0;
        bus.timeout_err = 1'b0;
        bus.grant       = in_service ? grant_q : '0;
        bus.busy        = (state_q != IDLE);
        unique case (state_q)
            CLEAR: begin
                bus.vga_x    = BOX_X0 + X_W'(clr_q[CB-1:0]);
                bus.vga_y    = BOX_Y0 + Y_W'(clr_q[CLR_W-1:CB]);
                bus.vga_plot = 1'b1;
            end
            LAUNCH: begin
                bus.eng_reset_n = grant_q;
                bus.eng_start   = grant_q;
            end
            DRAW: begin
                bus.eng_reset_n = grant_q;
                bus.vga_x       = bus.eng_x[x_off +: X_W];
                bus.vga_y       = bus.eng_y[y_off +: Y_W];
                bus.vga_plot    = bus.eng_plot[gidx_q];
                bus.vga_colour  = colour_q;
            end
            RELEASE: begin
                bus.ack         = err_q ? '0 : grant_q;
                bus.timeout_err = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ui_draw_sequencer.sv
// Directed bench for ui_draw_sequencer with an event scoreboard,
// behavioural engines and a negedge monitor for sweep and mux.
module tb_ui_draw_sequencer;
    import ui_draw_pkg::*;

    localparam int TB_TMO = 1000;
    localparam logic [1:0] K_START = 2'd0;
    localparam logic [1:0] K_ACK   = 2'd1;
    localparam logic [1:0] K_ERR   = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] mask;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n;
    ui_draw_sequencer_if bus ();

    ui_draw_sequencer #(.TIMEOUT_CYC(TB_TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    ev_t exp_q[$];
    logic [2:0] colours [4] = '{3'd5, 3'd6, 3'd3, 3'd7};
    int dly [4] = '{100, 100, 100, 100};
    logic noisy = 1'b0;
    logic [7:0] free = 8'd0;
    int ecnt [4] = '{0, 0, 0, 0};
    int cyc = 0;
    int start_cyc = 0;
    int pix = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [3:0] m);
        ev_t e;
        e.kind = k;
        e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [1:0] k, input logic [3:0] m,
                          input string tag);
        ev_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {k, m}, {e.kind, e.mask});
        end
    endtask

    // Engines: granted one counts up and raises done after dly cycles;
    // with noisy set, idle engines wiggle plot and done anyway.
    always @(posedge clk) begin
        free <= free + 8'd1;
        for (int i = 0; i < 4; i++) begin
            if (!bus.eng_reset_n[i]) begin
                ecnt[i]         <= 0;
                bus.eng_done[i] <= noisy;
            end else begin
                ecnt[i]         <= ecnt[i] + 1;
                bus.eng_done[i] <= (dly[i] != 0) && (ecnt[i] + 1 >= dly[i]);
            end
            bus.eng_x[8*i +: 8] <= 8'(i * 40) + free;
            bus.eng_y[7*i +: 7] <= 7'(i * 20) + free[6:0];
            bus.eng_plot[i] <= noisy ? (free[0] ^ i[0])
                                     : (bus.eng_reset_n[i] & free[0]);
        end
    end

    always @(negedge clk) begin
        int g;
        cyc++;
        if (!reset_n) begin
            pix = 0;
        end else begin
            if (bus.busy && bus.eng_reset_n == 4'b0 && bus.vga_plot) begin
                check("clear_px", {bus.vga_x, bus.vga_y, bus.vga_colour},
                      {8'(72 + pix % 16), 7'(56 + pix / 16), 3'd0});
                pix++;
            end
            if (bus.eng_start != 4'b0) begin
                check("clear_len", pix, 256);
                check("launch_rst", bus.eng_reset_n, bus.grant);
                check("launch_plot", bus.vga_plot, 0);
                pix = 0;
                start_cyc = cyc;
                sb_pop(K_START, bus.eng_start, "start");
            end else if (bus.eng_reset_n != 4'b0) begin
                g = int'(oh2idx(bus.grant));
                check("draw_rst", bus.eng_reset_n, bus.grant);
                check("draw_mux",
                      {bus.vga_x, bus.vga_y, bus.vga_plot, bus.vga_colour},
                      {bus.eng_x[8*g +: 8], bus.eng_y[7*g +: 7],
                       bus.eng_plot[g], colours[g]});
            end
            if (bus.ack != 4'b0) begin
                check("ack_err_excl", bus.timeout_err, 0);
                sb_pop(K_ACK, bus.ack, "ack");
            end
            if (bus.timeout_err) begin
                check("tmo_delay", cyc - start_cyc, TB_TMO + 1);
                sb_pop(K_ERR, bus.grant, "err");
            end
        end
    end

    task automatic pulse(input logic [3:0] r);
        @(posedge clk) #1 bus.req = r;
        @(posedge clk) #1 bus.req = 4'b0;
    endtask

    task automatic do_reset();
        @(posedge clk) #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_idle"}, bus.busy, 0);
        check({tag, "_grant0"}, bus.grant, 0);
    endtask

    task automatic abort_checks(input string tag);
        @(posedge clk) #1 reset_n = 1'b0;
        @(posedge clk) #1 reset_n = 1'b1;
        @(negedge clk);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_plot"}, bus.vga_plot, 0);
        check({tag, "_grant"}, bus.grant, 0);
        check({tag, "_pulses"}, {bus.ack, bus.timeout_err}, 0);
        repeat (300) @(negedge clk);
        check({tag, "_pend0"}, bus.busy, 0);
        check({tag, "_sb"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        bus.req = 4'b0;
        bus.req_colour = {colours[3], colours[2], colours[1], colours[0]};
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_grant", bus.grant, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_plot", bus.vga_plot, 0);
        check("rst_engrst", bus.eng_reset_n, 0);
        check("rst_pulses", {bus.eng_start, bus.ack, bus.timeout_err}, 0);
        @(posedge clk) #1 reset_n = 1'b1;

        push(K_START, 4'b0010);
        push(K_ACK, 4'b0010);
        pulse(4'b0010);
        drain("single", 2000);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(K_START, 4'(1 << i));
            push(K_ACK, 4'(1 << i));
        end
        pulse(4'b1111);
        n = 0;
        while (bus.grant != 4'b1000 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("grant3_seen", bus.grant, 4'b1000);
        push(K_START, 4'b0001);
        push(K_ACK, 4'b0001);
        push(K_START, 4'b1000);
        push(K_ACK, 4'b1000);
        pulse(4'b1001);
        drain("rr", 6000);

        do_reset();
        noisy = 1'b1;
        dly[2] = 0;
        push(K_START, 4'b0100);
        push(K_ERR, 4'b0100);
        pulse(4'b0100);
        drain("tmo", 3000);
        repeat (20) @(negedge clk);
        check("tmo_pend2_clr", bus.busy, 0);
        noisy = 1'b0;
        dly[2] = 100;

        do_reset();
        pulse(4'b0001);
        repeat (50) @(posedge clk);
        abort_checks("abort_clear");

        push(K_START, 4'b0100);
        pulse(4'b0100);
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_draw_started", exp_q.size(), 0);
        repeat (20) @(posedge clk);
        abort_checks("abort_draw");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
